// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse letter decoder: widths, the A..H
// pattern table (MSB = first symbol bit) and the FSM state encoding.
package morse_pkg;

  localparam int PATTERN_W   = 12;
  localparam int LETTER_W    = 3;
  localparam int NUM_LETTERS = 8;
  localparam int COUNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    MATCH
  } state_t;

  localparam logic [PATTERN_W-1:0] PAT_A = 12'b101110000000;
  localparam logic [PATTERN_W-1:0] PAT_B = 12'b111010101000;
  localparam logic [PATTERN_W-1:0] PAT_C = 12'b111010111010;
  localparam logic [PATTERN_W-1:0] PAT_D = 12'b111010100000;
  localparam logic [PATTERN_W-1:0] PAT_E = 12'b100000000000;
  localparam logic [PATTERN_W-1:0] PAT_F = 12'b101011101000;
  localparam logic [PATTERN_W-1:0] PAT_G = 12'b111011101000;
  localparam logic [PATTERN_W-1:0] PAT_H = 12'b101010100000;

  // Element i holds the pattern whose letter code is i.
  localparam logic [NUM_LETTERS-1:0][PATTERN_W-1:0] LETTER_PATTERNS =
    {PAT_H, PAT_G, PAT_F, PAT_E, PAT_D, PAT_C, PAT_B, PAT_A};

  typedef struct packed {
    logic                hit;
    logic [LETTER_W-1:0] code;
  } match_t;

  function automatic match_t lookup_letter(input logic [PATTERN_W-1:0] pattern);
    match_t m;
    m = '0;
    for (int i = 0; i < NUM_LETTERS; i++) begin
      if (pattern == LETTER_PATTERNS[i]) begin
        m.hit  = 1'b1;
        m.code = LETTER_W'(i);
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/morse_timeout.sv
// Inter-bit timeout: reloads to CLOCK_FREQUENCY-1, counts down to zero and
// flags expiry while the count sits at zero.
module morse_timeout #(
  parameter int CLOCK_FREQUENCY = 100
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_dec,
  output logic o_expired
);

  localparam int CNT_W = (CLOCK_FREQUENCY > 1) ? $clog2(CLOCK_FREQUENCY) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLOCK_FREQUENCY - 1);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values, independent of process ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= RELOAD;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/morse_decoder.sv
// Serial Morse decoder for letters A..H with inter-bit timeout.
// Optional error tally enabled by defining MORSE_DECODER_ERRCNT_EN.
module morse_decoder
  import morse_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 100
) (
  input  logic                ClockIn,
  input  logic                Resetn,
  input  logic                DotDashIn,
  input  logic                NewBitIn,
  output logic [LETTER_W-1:0] Letter,
  output logic                Valid,
  output logic                Error,
  output logic                Busy,
  output logic [7:0]          ErrCount
);

  state_t               r_state, w_state_next;
  logic [PATTERN_W-1:0] r_shift, w_shift_next;
  logic [COUNT_W-1:0]   r_bit_count, w_bit_count_next;
  logic [LETTER_W-1:0]  r_letter, w_letter_next;
  logic                 r_valid, w_valid_next;
  logic                 r_error, w_error_next;
  logic                 w_to_load, w_to_dec, w_to_expired;
  match_t               w_match;

  assign w_match = lookup_letter(r_shift);

  morse_timeout #(
    .CLOCK_FREQUENCY(CLOCK_FREQUENCY)
  ) u_timeout (
    .i_clk    (ClockIn),
    .i_rst_n  (Resetn),
    .i_load   (w_to_load),
    .i_dec    (w_to_dec),
    .o_expired(w_to_expired)
  );

  always_ff @(posedge ClockIn or negedge Resetn) begin
    if (!Resetn) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_bit_count <= '0;
      r_letter    <= '0;
      r_valid     <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_shift     <= w_shift_next;
      r_bit_count <= w_bit_count_next;
      r_letter    <= w_letter_next;
      r_valid     <= w_valid_next;
      r_error     <= w_error_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned and infers a latch.
    w_state_next     = r_state;
    w_shift_next     = r_shift;
    w_bit_count_next = r_bit_count;
    w_letter_next    = r_letter;
    w_valid_next     = 1'b0;
    w_error_next     = 1'b0;
    w_to_load        = 1'b0;
    w_to_dec         = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (NewBitIn && DotDashIn) begin
          w_shift_next     = PATTERN_W'(1);
          w_bit_count_next = COUNT_W'(1);
          w_to_load        = 1'b1;
          w_state_next     = CAPTURE;
        end
      end
      CAPTURE: begin
        // A strobe takes priority over a simultaneous expiry.
        if (NewBitIn) begin
          w_shift_next     = {r_shift[PATTERN_W-2:0], DotDashIn};
          w_bit_count_next = r_bit_count + 1'b1;
          w_to_load        = 1'b1;
          if (r_bit_count == COUNT_W'(PATTERN_W - 1)) begin
            w_state_next = MATCH;
          end
        end else if (w_to_expired) begin
          w_error_next     = 1'b1;
          w_shift_next     = '0;
          w_bit_count_next = '0;
          w_state_next     = IDLE;
        end else begin
          w_to_dec = 1'b1;
        end
      end
      MATCH: begin
        if (w_match.hit) begin
          w_letter_next = w_match.code;
          w_valid_next  = 1'b1;
        end else begin
          w_error_next = 1'b1;
        end
        w_shift_next     = '0;
        w_bit_count_next = '0;
        w_state_next     = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

`ifdef MORSE_DECODER_ERRCNT_EN
  logic [7:0] r_err_count;

  always_ff @(posedge ClockIn or negedge Resetn) begin
    if (!Resetn) begin
      r_err_count <= '0;
    end else if (w_error_next && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign ErrCount = r_err_count;
`else
  assign ErrCount = '0;
`endif

  assign Letter = r_letter;
  assign Valid  = r_valid;
  assign Error  = r_error;
  assign Busy   = (r_state != IDLE);

endmodule

// File: tb/tb_morse_decoder.sv
// Directed self-checking bench for morse_decoder (CLOCK_FREQUENCY = 100).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_morse_decoder;

  logic       ClockIn;
  logic       Resetn;
  logic       DotDashIn;
  logic       NewBitIn;
  logic [2:0] Letter;
  logic       Valid;
  logic       Error;
  logic       Busy;
  logic [7:0] ErrCount;

  int total = 0;
  int bad   = 0;
  int n_valid = 0;
  int n_err   = 0;
  int n_both  = 0;
  int v0, e0;

`ifdef MORSE_DECODER_ERRCNT_EN
  localparam int EC_ON = 1;
`else
  localparam int EC_ON = 0;
`endif

  morse_decoder #(
    .CLOCK_FREQUENCY(100)
  ) dut (
    .ClockIn  (ClockIn),
    .Resetn   (Resetn),
    .DotDashIn(DotDashIn),
    .NewBitIn (NewBitIn),
    .Letter   (Letter),
    .Valid    (Valid),
    .Error    (Error),
    .Busy     (Busy),
    .ErrCount (ErrCount)
  );

  initial begin
    ClockIn = 1'b0;
    forever #5 ClockIn = ~ClockIn;
  end

  // Pulse tally, sampled just after each rising edge.
  always begin
    @(posedge ClockIn);
    #1;
    if (Valid) n_valid++;
    if (Error) n_err++;
    if (Valid && Error) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge ClockIn);
  endtask

  task automatic strobe(input logic b);
    NewBitIn  = 1'b1;
    DotDashIn = b;
    @(negedge ClockIn);
    NewBitIn  = 1'b0;
    DotDashIn = 1'b0;
  endtask

  task automatic send_pattern(input logic [11:0] p, input int gap);
    for (int i = 11; i >= 0; i--) begin
      strobe(p[i]);
      if (i > 0) idle(gap - 1);
    end
  endtask

  task automatic expect_letter(input string tag, input logic [11:0] p, input int gap,
                               input logic [2:0] exp_letter);
    v0 = n_valid;
    e0 = n_err;
    send_pattern(p, gap);
    check({tag, ".busy_match"}, Busy, 1);
    check({tag, ".valid_early"}, Valid, 0);
    idle(1);
    check({tag, ".valid"}, Valid, 1);
    check({tag, ".letter"}, Letter, exp_letter);
    check({tag, ".error"}, Error, 0);
    check({tag, ".busy_done"}, Busy, 0);
    idle(1);
    check({tag, ".valid_drop"}, Valid, 0);
    check({tag, ".valid_count"}, n_valid - v0, 1);
    check({tag, ".err_count"}, n_err - e0, 0);
  endtask

  initial begin
    Resetn    = 1'b1;
    DotDashIn = 1'b0;
    NewBitIn  = 1'b0;
    #1 Resetn = 1'b0;
    idle(2);
    check("rst.letter", Letter, 0);
    check("rst.valid", Valid, 0);
    check("rst.error", Error, 0);
    check("rst.busy", Busy, 0);
    check("rst.errcount", ErrCount, 0);
    Resetn = 1'b1;
    idle(1);

    expect_letter("C_slow", 12'b111010111010, 26, 3'b010);

    // Unmatched pattern: error pulse, letter holds.
    v0 = n_valid;
    e0 = n_err;
    send_pattern(12'b110000000000, 1);
    idle(1);
    check("unk.error", Error, 1);
    check("unk.valid", Valid, 0);
    check("unk.letter", Letter, 3'b010);
    check("unk.errcount", ErrCount, EC_ON * 1);
    idle(1);
    check("unk.error_drop", Error, 0);
    check("unk.err_pulses", n_err - e0, 1);
    check("unk.valid_pulses", n_valid - v0, 0);

    // Timeout: error exactly 100 cycles after the last strobe.
    v0 = n_valid;
    e0 = n_err;
    strobe(1); strobe(0); strobe(1); strobe(1); strobe(1);
    idle(99);
    check("to.error_early", Error, 0);
    check("to.busy_wait", Busy, 1);
    idle(1);
    check("to.error", Error, 1);
    check("to.busy_after", Busy, 0);
    check("to.letter", Letter, 3'b010);
    idle(1);
    check("to.error_drop", Error, 0);
    check("to.err_pulses", n_err - e0, 1);
    check("to.valid_pulses", n_valid - v0, 0);
    check("to.errcount", ErrCount, EC_ON * 2);

    // Leading gaps never start a capture.
    for (int i = 0; i < 3; i++) begin
      strobe(0);
      check("gap.busy", Busy, 0);
    end
    expect_letter("E", 12'b100000000000, 1, 3'b100);

    expect_letter("B", 12'b111010101000, 3, 3'b001);
    expect_letter("F", 12'b101011101000, 1, 3'b101);
    expect_letter("D", 12'b111010100000, 2, 3'b011);
    expect_letter("G", 12'b111011101000, 1, 3'b110);

    // Each strobe lands exactly on the expiry cycle; the strobe must win.
    expect_letter("H_edge", 12'b101010100000, 100, 3'b111);

    // Asynchronous reset in the middle of a capture.
    strobe(1); strobe(0); strobe(1); strobe(0); strobe(1); strobe(0);
    check("mid.busy", Busy, 1);
    #2 Resetn = 1'b0;
    #1;
    check("mid.letter", Letter, 0);
    check("mid.valid", Valid, 0);
    check("mid.error", Error, 0);
    check("mid.busy_rst", Busy, 0);
    check("mid.errcount", ErrCount, 0);
    idle(1);
    Resetn = 1'b1;
    idle(1);
    expect_letter("A_after_rst", 12'b101110000000, 2, 3'b000);

    // Back-to-back: a 1-strobe in the MATCH cycle is dropped.
    send_pattern(12'b111010100000, 1);
    strobe(1);
    check("b2b.valid", Valid, 1);
    check("b2b.letter", Letter, 3'b011);
    check("b2b.busy", Busy, 0);
    expect_letter("G_b2b", 12'b111011101000, 1, 3'b110);

    check("never_both", n_both, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
